// File: rtl/slave_rd_requester.sv
// Slave-port read initiator: forwards one client read to the master port and returns data/error.
// Optional RD_TIMEOUT_EN macro turns a missing m_ack into an error response after TIMEOUT cycles.
module slave_rd_requester #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              s_valid,
  input  logic [AWIDTH-1:0] s_addr,
  output logic              s_ready,
  output logic              s_rvalid,
  output logic [DWIDTH-1:0] s_rdata,
  output logic              s_rerr,
  input  logic              s_rready,
  output logic              m_req,
  output logic [AWIDTH-1:0] m_addr,
  input  logic [DWIDTH-1:0] m_rdata,
  input  logic              m_resp,
  input  logic              m_ack
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic              m_req_nxt, s_rvalid_nxt, s_rerr_nxt;
  logic [AWIDTH-1:0] m_addr_nxt;
  logic [DWIDTH-1:0] s_rdata_nxt;

`ifdef RD_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 32) ? 32 : CW_RAW);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt, cnt_nxt;
`endif

  assign s_ready = (state == IDLE);

  always_comb begin
    state_nxt    = state;
    m_req_nxt    = m_req;
    m_addr_nxt   = m_addr;
    s_rvalid_nxt = s_rvalid;
    s_rdata_nxt  = s_rdata;
    s_rerr_nxt   = s_rerr;
`ifdef RD_TIMEOUT_EN
    cnt_nxt      = cnt;
`endif
    case (state)
      IDLE: begin
        // m_ack here is a stale or late response and is ignored
        if (s_valid) begin
          m_addr_nxt = s_addr;
          m_req_nxt  = 1'b1;
          state_nxt  = WAIT;
`ifdef RD_TIMEOUT_EN
          cnt_nxt    = '0;
`endif
        end
      end
      WAIT: begin
        if (m_ack) begin
          s_rdata_nxt  = m_rdata;
          s_rerr_nxt   = m_resp;
          m_req_nxt    = 1'b0;
          s_rvalid_nxt = 1'b1;
          state_nxt    = RESP;
        end
`ifdef RD_TIMEOUT_EN
        // An ack arriving on the expiry cycle takes precedence over the timeout
        else if (cnt == CNT_LAST) begin
          s_rdata_nxt  = '0;
          s_rerr_nxt   = 1'b1;
          m_req_nxt    = 1'b0;
          s_rvalid_nxt = 1'b1;
          state_nxt    = RESP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      RESP: begin
        if (s_rready) begin
          s_rvalid_nxt = 1'b0;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= IDLE;
      m_req    <= 1'b0;
      m_addr   <= '0;
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rerr   <= 1'b0;
`ifdef RD_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      state    <= state_nxt;
      m_req    <= m_req_nxt;
      m_addr   <= m_addr_nxt;
      s_rvalid <= s_rvalid_nxt;
      s_rdata  <= s_rdata_nxt;
      s_rerr   <= s_rerr_nxt;
`ifdef RD_TIMEOUT_EN
      cnt      <= cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_slave_rd_requester.sv
// Directed bench for slave_rd_requester with a queue scoreboard of expected read results.
module tb_slave_rd_requester;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_valid;
  logic [AW-1:0] s_addr;
  logic          s_ready;
  logic          s_rvalid;
  logic [DW-1:0] s_rdata;
  logic          s_rerr;
  logic          s_rready;
  logic          m_req;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_rdata;
  logic          m_resp;
  logic          m_ack;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  slave_rd_requester #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(16)) dut (
    .aclk(aclk), .areset(areset),
    .s_valid(s_valid), .s_addr(s_addr), .s_ready(s_ready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rerr(s_rerr), .s_rready(s_rready),
    .m_req(m_req), .m_addr(m_addr), .m_rdata(m_rdata), .m_resp(m_resp), .m_ack(m_ack)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic accept(input logic [AW-1:0] a, input string tag);
    s_valid = 1'b1;
    s_addr  = a;
    tick();
    s_valid = 1'b0;
    check({tag, " m_req"}, m_req, 1);
    check({tag, " m_addr"}, m_addr, a);
    check({tag, " s_ready"}, s_ready, 0);
  endtask

  task automatic ack(input logic [DW-1:0] d, input logic r, input string tag);
    exp_t e;
    m_ack   = 1'b1;
    m_rdata = d;
    m_resp  = r;
    e.d = d;
    e.e = r;
    q.push_back(e);
    tick();
    m_ack   = 1'b0;
    m_rdata = '0;
    m_resp  = 1'b0;
    check({tag, " rvalid latency"}, s_rvalid, 1);
    check({tag, " m_req drop"}, m_req, 0);
  endtask

  task automatic do_result(input string tag);
    exp_t e;
    int   n = 0;
    e.d = '0;
    e.e = 1'b0;
    while (!s_rvalid && n < 50) begin
      tick();
      n++;
    end
    check({tag, " rvalid"}, s_rvalid, 1);
    if (q.size() > 0) e = q.pop_front();
    check({tag, " rdata"}, s_rdata, e.d);
    check({tag, " rerr"}, s_rerr, e.e);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    check({tag, " rvalid clr"}, s_rvalid, 0);
    check({tag, " s_ready back"}, s_ready, 1);
  endtask

  initial begin
    areset = 1'b1;
    s_valid = 1'b0; s_addr = '0; s_rready = 1'b0;
    m_rdata = '0; m_resp = 1'b0; m_ack = 1'b0;
    tick();
    tick();
    areset = 1'b0;
    tick();
    check("reset s_ready", s_ready, 1);
    check("reset m_req", m_req, 0);
    check("reset m_addr", m_addr, 0);
    check("reset s_rvalid", s_rvalid, 0);
    check("reset s_rdata", s_rdata, 0);
    check("reset s_rerr", s_rerr, 0);

    // basic read, ack three cycles after m_req rises
    accept(32'h100, "basic");
    for (int i = 0; i < 2; i++) begin
      tick();
      check("basic m_req hold", m_req, 1);
      check("basic m_addr hold", m_addr, 32'h100);
    end
    ack(32'hDEADBEEF, 1'b0, "basic");
    do_result("basic");

    // error response at minimum latency
    accept(32'h200, "err");
    ack(32'h5, 1'b1, "err");
    do_result("err");

    // backpressure with a stray ack in RESP
    accept(32'h300, "bp");
    tick();
    ack(32'hCAFEF00D, 1'b0, "bp");
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        m_ack = 1'b1; m_rdata = 32'h1111; m_resp = 1'b1;
      end
      tick();
      m_ack = 1'b0; m_rdata = '0; m_resp = 1'b0;
      check("bp rvalid", s_rvalid, 1);
      check("bp rdata", s_rdata, 32'hCAFEF00D);
      check("bp rerr", s_rerr, 0);
      check("bp s_ready", s_ready, 0);
    end
    do_result("bp");

    // stray ack in IDLE
    m_ack = 1'b1; m_rdata = 32'h1234; m_resp = 1'b1;
    tick();
    m_ack = 1'b0; m_rdata = '0; m_resp = 1'b0;
    tick();
    check("idle ack rvalid", s_rvalid, 0);
    check("idle ack m_req", m_req, 0);
    check("idle ack s_ready", s_ready, 1);
    check("idle ack rdata", s_rdata, 32'hCAFEF00D);
    check("idle ack rerr", s_rerr, 0);

    // held request while busy, then reset mid-WAIT
    accept(32'h400, "rst");
    s_valid = 1'b1; s_addr = 32'h444;
    tick();
    tick();
    check("busy m_addr", m_addr, 32'h400);
    check("busy s_ready", s_ready, 0);
    s_valid = 1'b0;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("rst m_req", m_req, 0);
    check("rst s_rvalid", s_rvalid, 0);
    check("rst s_ready", s_ready, 1);
    check("rst m_addr", m_addr, 0);
    m_ack = 1'b1; m_rdata = 32'h9999; m_resp = 1'b0;
    tick();
    m_ack = 1'b0; m_rdata = '0;
    tick();
    check("post-rst ack rvalid", s_rvalid, 0);
    check("post-rst ack s_ready", s_ready, 1);
    check("post-rst ack rdata", s_rdata, 0);

`ifdef RD_TIMEOUT_EN
    // no ack: error result 16 cycles after m_req rose
    accept(32'h500, "to");
    for (int i = 1; i < 16; i++) begin
      tick();
      check("to waiting", s_rvalid, 0);
    end
    begin
      exp_t e;
      e.d = '0;
      e.e = 1'b1;
      q.push_back(e);
    end
    tick();
    check("to expire", s_rvalid, 1);
    check("to m_req", m_req, 0);
    do_result("to");

    // ack on the expiry cycle wins
    accept(32'h600, "to-ack");
    for (int i = 1; i < 16; i++) tick();
    ack(32'h77, 1'b0, "to-ack");
    do_result("to-ack");
`else
    // without a timeout the read waits indefinitely
    accept(32'h500, "long");
    for (int i = 0; i < 40; i++) tick();
    check("long m_req", m_req, 1);
    check("long rvalid", s_rvalid, 0);
    ack(32'h77, 1'b0, "long");
    do_result("long");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
